// File: rtl/rv32_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter_pkg
//   Shared definitions for the rv32 core <-> cache request arbiter:
//   FSM state encoding, transaction owner encoding and default widths.
// ----------------------------------------------------------------------------
package rv32_mem_arbiter_pkg;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter_if
//   Bundles the three buses around the arbiter:
//     i_req_* / i_rsp_*  instruction-fetch side of the core
//     d_req_* / d_rsp_*  load/store side of the core
//     c_req_* / c_rsp_*  single request port of the cache
//   modport master : the arbiter (accepts core requests, masters the cache port)
//   modport slave  : the environment (core requesters and the cache)
// ----------------------------------------------------------------------------
interface rv32_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_W-1:0]     i_req_addr;
    logic                  i_rsp_valid;
    logic [DATA_W-1:0]     i_rsp_rdata;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_W-1:0]     d_req_addr;
    logic                  d_req_we;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_wstrb;
    logic                  d_rsp_valid;
    logic [DATA_W-1:0]     d_rsp_rdata;

    logic                  c_req_valid;
    logic                  c_req_ready;
    logic [ADDR_W-1:0]     c_req_addr;
    logic                  c_req_we;
    logic [DATA_W-1:0]     c_req_wdata;
    logic [DATA_W/8-1:0]   c_req_wstrb;
    logic                  c_rsp_valid;
    logic [DATA_W-1:0]     c_rsp_rdata;

    modport master (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_rdata,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output c_req_valid, c_req_addr, c_req_we, c_req_wdata, c_req_wstrb,
        input  c_req_ready, c_rsp_valid, c_rsp_rdata
    );

    modport slave (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  c_req_valid, c_req_addr, c_req_we, c_req_wdata, c_req_wstrb,
        output c_req_ready, c_rsp_valid, c_rsp_rdata
    );
endinterface

// File: rtl/rv32_mem_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rv32_arb_pick
//   Winner select for the arbiter: data side wins unless fetch has watched
//   STARVE_MAX consecutive data grants, in which case fetch is forced through.
//   Ports:
//     clk, rst      clock / async active-high reset
//     idle_i        arbiter is in IDLE and may grant this cycle
//     i_valid_i     fetch request pending
//     d_valid_i     load/store request pending
//     grant_i_o     fetch wins this cycle (combinational)
//     grant_d_o     load/store wins this cycle (combinational)
// ----------------------------------------------------------------------------
module rv32_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic i_valid_i,
    input  logic d_valid_i,
    output logic grant_i_o,
    output logic grant_d_o
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved = (cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        grant_i_o = 1'b0;
        grant_d_o = 1'b0;
        cnt_d     = cnt_q;
        if (idle_i) begin
            if (d_valid_i && !(starved && i_valid_i))
                grant_d_o = 1'b1;
            else if (i_valid_i)
                grant_i_o = 1'b1;

            // Count only D grants that fetch actually watched; a fetch grant or
            // an idle cycle with no fetch pending restarts the window.
            if (!i_valid_i || grant_i_o)
                cnt_d = '0;
            else if (grant_d_o && !starved)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter
//   Shares the cache request port between the core's fetch (I) and load/store
//   (D) sides. One transaction outstanding; the response goes back to the side
//   that issued it.
//   Ports:
//     clk, rst        clock / async active-high reset
//     bus (master)    I/D request+response buses and the cache request port
//     err_spurious_o  1-cycle pulse: cache response seen outside WAIT_RSP
// ----------------------------------------------------------------------------
module rv32_mem_arbiter
    import rv32_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_mem_arbiter_if.master   bus,
    output logic                 err_spurious_o
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                i_rsp_valid_q, i_rsp_valid_d;
    logic                d_rsp_valid_q, d_rsp_valid_d;
    logic [DATA_W-1:0]   i_rsp_rdata_q, i_rsp_rdata_d;
    logic [DATA_W-1:0]   d_rsp_rdata_q, d_rsp_rdata_d;
    logic                err_q, err_d;

    logic                can_grant;
    logic                grant_i, grant_d;

    // Readies are combinational from state, so hold them off while reset is
    // asserted even though the state register already reads IDLE.
    assign can_grant = (state_q == ST_IDLE) && !rst;

    rv32_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk       (clk),
        .rst       (rst),
        .idle_i    (can_grant),
        .i_valid_i (bus.i_req_valid),
        .d_valid_i (bus.d_req_valid),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        i_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        i_rsp_rdata_d = i_rsp_rdata_q;
        d_rsp_rdata_d = d_rsp_rdata_q;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                err_d = bus.c_rsp_valid;
                if (grant_d) begin
                    owner_d = OWNER_D;
                    addr_d  = bus.d_req_addr;
                    we_d    = bus.d_req_we;
                    wdata_d = bus.d_req_wdata;
                    wstrb_d = bus.d_req_wstrb;
                    state_d = ST_ISSUE;
                end else if (grant_i) begin
                    // Fetch is always a plain read.
                    owner_d = OWNER_I;
                    addr_d  = bus.i_req_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A response in the acceptance cycle itself is a cache error.
                err_d = bus.c_rsp_valid;
                if (bus.c_req_ready) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (bus.c_rsp_valid) begin
                    if (owner_q == OWNER_I) begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_rdata_d = bus.c_rsp_rdata;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_rdata_d = bus.c_rsp_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= OWNER_D;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_rsp_rdata_q <= '0;
            d_rsp_rdata_q <= '0;
            err_q         <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            i_rsp_rdata_q <= i_rsp_rdata_d;
            d_rsp_rdata_q <= d_rsp_rdata_d;
            err_q         <= err_d;
        end
    end

    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;
    assign bus.i_rsp_valid = i_rsp_valid_q;
    assign bus.i_rsp_rdata = i_rsp_rdata_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_rdata = d_rsp_rdata_q;
    assign bus.c_req_valid = (state_q == ST_ISSUE);
    assign bus.c_req_addr  = addr_q;
    assign bus.c_req_we    = we_q;
    assign bus.c_req_wdata = wdata_q;
    assign bus.c_req_wstrb = wstrb_q;
    assign err_spurious_o  = err_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
module tb_rv32_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_spurious;
    always #5 clk = ~clk;

    rv32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rv32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .err_spurious_o (err_spurious)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // stimulus knobs
    int p_i = 0, p_d = 0;
    bit spur_en = 0, slow_rsp = 0;

    // handshake observations from the monitor, consumed by drivers
    bit i_acc = 0, d_acc = 0;

    // reference model: transaction phase 0=free 1=request out 2=awaiting data
    typedef struct { bit side_d; logic [DW-1:0] data; } rsp_t;
    rsp_t rsp_q[$];
    int   m_phase = 0;
    int   d_streak = 0;    // D grants in a row that fetch had to watch
    bit   m_owner_d;
    logic [AW-1:0] e_addr;
    logic [36:0]   e_ctl;  // {we, wstrb, wdata}
    bit   err_due = 0, rsp_due = 0;
    int   i_grants = 0, d_grants = 0;

    // fetch requester: holds a request until accepted
    initial begin
        bus.i_req_valid = 0; bus.i_req_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (!bus.i_req_valid || i_acc) begin
                bus.i_req_valid = ($urandom_range(0, 99) < p_i);
                bus.i_req_addr  = $urandom;
            end
        end
    end

    // load/store requester
    initial begin
        bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_we = 0;
        bus.d_req_wdata = '0; bus.d_req_wstrb = '0;
        forever begin
            @(posedge clk); #1;
            if (!bus.d_req_valid || d_acc) begin
                bus.d_req_valid = ($urandom_range(0, 99) < p_d);
                bus.d_req_addr  = $urandom;
                bus.d_req_we    = 1'($urandom_range(0, 1));
                bus.d_req_wdata = $urandom;
                bus.d_req_wstrb = SW'($urandom_range(0, 15));
            end
        end
    end

    // cache model: random accept stalls, response 1..3 cycles after acceptance
    initial begin
        bit acc_prev, outst;
        int dly;
        acc_prev = 0; outst = 0; dly = 0;
        bus.c_req_ready = 0; bus.c_rsp_valid = 0; bus.c_rsp_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (acc_prev) begin outst = 1; dly = slow_rsp ? 2 : $urandom_range(0, 2); end
            bus.c_rsp_valid = 0;
            if (outst) begin
                if (dly == 0) begin
                    bus.c_rsp_valid = 1; bus.c_rsp_rdata = $urandom; outst = 0;
                end else dly--;
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                bus.c_rsp_valid = 1; bus.c_rsp_rdata = $urandom;
            end
            bus.c_req_ready = bus.c_req_valid && ($urandom_range(0, 99) < 60);
            acc_prev = bus.c_req_valid && bus.c_req_ready;
        end
    end

    // monitor + reference model, evaluated mid-cycle
    always @(negedge clk) begin
        bit exp_gi, exp_gd, err_next, rsp_next, pulse;
        rsp_t r;
        if (rst) begin
            check("rst_outputs", {bus.i_req_ready, bus.d_req_ready, bus.c_req_valid,
                  bus.i_rsp_valid, bus.d_rsp_valid, err_spurious}, 0);
            m_phase = 0; d_streak = 0; err_due = 0; rsp_due = 0;
            rsp_q.delete(); i_acc = 0; d_acc = 0;
        end else begin
            pulse = bus.i_rsp_valid | bus.d_rsp_valid;
            check("rsp_pulse", pulse, rsp_due);
            if (pulse && rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                check("rsp_side", {bus.i_rsp_valid, bus.d_rsp_valid}, r.side_d ? 2'b01 : 2'b10);
                check("rsp_data", r.side_d ? bus.d_rsp_rdata : bus.i_rsp_rdata, r.data);
            end
            check("err_spurious", err_spurious, err_due);

            exp_gi = 0; exp_gd = 0;
            if (m_phase == 0) begin
                if (bus.d_req_valid && !(d_streak == SM && bus.i_req_valid)) exp_gd = 1;
                else if (bus.i_req_valid) exp_gi = 1;
            end
            check("req_ready", {bus.i_req_ready, bus.d_req_ready}, {exp_gi, exp_gd});
            check("c_req_valid", bus.c_req_valid, m_phase == 1);
            if (m_phase == 1) begin
                check("c_req_addr", bus.c_req_addr, e_addr);
                check("c_req_ctl", {bus.c_req_we, bus.c_req_wstrb, bus.c_req_wdata}, e_ctl);
            end

            err_next = bus.c_rsp_valid && (m_phase != 2);
            rsp_next = 0;
            case (m_phase)
                0: begin
                    if (exp_gd) begin
                        m_owner_d = 1; e_addr = bus.d_req_addr;
                        e_ctl = {bus.d_req_we, bus.d_req_wstrb, bus.d_req_wdata};
                        m_phase = 1; d_grants++;
                    end else if (exp_gi) begin
                        m_owner_d = 0; e_addr = bus.i_req_addr; e_ctl = '0;
                        m_phase = 1; i_grants++;
                    end
                    if (exp_gi || !bus.i_req_valid) d_streak = 0;
                    else if (exp_gd && d_streak < SM) d_streak++;
                end
                1: if (bus.c_req_ready) m_phase = 2;
                2: if (bus.c_rsp_valid) begin
                    rsp_q.push_back('{side_d: m_owner_d, data: bus.c_rsp_rdata});
                    rsp_next = 1; m_phase = 0;
                end
                default: m_phase = 0;
            endcase
            err_due = err_next; rsp_due = rsp_next;
            i_acc = bus.i_req_valid && bus.i_req_ready;
            d_acc = bus.d_req_valid && bus.d_req_ready;
        end
    end

    initial begin
        int n, ig0;
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_c_addr", bus.c_req_addr, 0);
        check("rst_rdata", {bus.i_rsp_rdata, bus.d_rsp_rdata}, 0);
        @(posedge clk); #1 rst = 0;

        // mixed traffic with spurious responses
        p_i = 50; p_d = 50; spur_en = 1;
        repeat (400) @(posedge clk);

        // both sides saturated: fetch must still get through
        p_i = 100; p_d = 100; spur_en = 0;
        ig0 = i_grants;
        repeat (200) @(posedge clk);
        tests++;
        if (i_grants - ig0 < 3) begin
            fails++;
            $display("FAIL starve_guard: got %0d fetch grants expected at least 3", i_grants - ig0);
        end

        // reset while awaiting the cache response; late response is spurious
        slow_rsp = 1; n = 0;
        while (m_phase != 2 && n < 200) begin @(negedge clk); n++; end
        check("wait_rsp_reached", m_phase, 2);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (3) @(posedge clk);
        slow_rsp = 0;

        // idle with stray cache responses
        p_i = 0; p_d = 0; spur_en = 1;
        repeat (100) @(posedge clk);

        p_i = 70; p_d = 40; spur_en = 1;
        repeat (300) @(posedge clk);

        // drain
        p_i = 0; p_d = 0; spur_en = 0; n = 0;
        while ((bus.i_req_valid || bus.d_req_valid || m_phase != 0 || rsp_due) && n < 500) begin
            @(negedge clk); n++;
        end
        check("drain_done", n < 500, 1);
        repeat (3) @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
